// File: rtl/uart_pixel_packer.sv
// uart_pixel_packer
// Turns a UART byte stream into RGB565 pixels. A frame starts with the two
// sync bytes HEADER0/HEADER1. It is followed by FRAME_PIXELS big-endian
// byte pairs. If the line stays idle for too long during a frame, the frame
// is aborted.
//
// Handshake: rx_data_vld is a single-cycle strobe. The block has no ready
// signal and accepts a byte on every cycle where rx_data_vld is high, so
// back-to-back bytes are never dropped. bit16_out_vld, frame_done and
// frame_err are single-cycle pulses. bit16_out holds its last value
// whenever bit16_out_vld is low.
//
// state_dbg exposes the FSM encoding: 0 = HDR0, 1 = HDR1, 2 = RECV.

module uart_pixel_packer #(
    parameter int unsigned FRAME_PIXELS   = 921600,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  HEADER0        = 8'hA5,
    parameter logic [7:0]  HEADER1        = 8'h5A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_vld,
    output logic [15:0] bit16_out,
    output logic        bit16_out_vld,
    output logic        frame_busy,
    output logic        frame_done,
    output logic        frame_err,
    output logic [19:0] pix_cnt,
    output logic [1:0]  state_dbg
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX   = {TW{1'b1}};
    localparam logic [19:0]   PIX_LAST = 20'(FRAME_PIXELS - 1);

    typedef enum logic [1:0] {
        HDR0 = 2'd0,
        HDR1 = 2'd1,
        RECV = 2'd2
    } state_t;

    state_t        state;
    logic [TW-1:0] to_cnt;
    logic          byte_phase;
    logic [7:0]    hi_byte;
    logic          timeout_hit;

    // A byte arriving on the timeout cycle wins, so a timeout only fires on an idle cycle.
    assign timeout_hit = (state != HDR0) && !rx_data_vld && (to_cnt == TO_LAST);

    // Debug view of the FSM encoding.
    assign state_dbg = state;

    // Header sync, byte pairing, pixel counting and idle timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= HDR0;
            to_cnt        <= '0;
            byte_phase    <= 1'b0;
            hi_byte       <= 8'h00;
            bit16_out     <= 16'h0000;
            bit16_out_vld <= 1'b0;
            frame_busy    <= 1'b0;
            frame_done    <= 1'b0;
            frame_err     <= 1'b0;
            pix_cnt       <= 20'd0;
        end else begin
            bit16_out_vld <= 1'b0;
            frame_done    <= 1'b0;
            frame_err     <= 1'b0;
            case (state)
                HDR0: begin
                    to_cnt <= '0;
                    if (rx_data_vld && rx_data == HEADER0) begin
                        state <= HDR1;
                    end
                end
                HDR1: begin
                    if (rx_data_vld) begin
                        to_cnt <= '0;
                        if (rx_data == HEADER1) begin
                            state      <= RECV;
                            frame_busy <= 1'b1;
                            pix_cnt    <= 20'd0;
                            byte_phase <= 1'b0;
                        end else if (rx_data != HEADER0) begin
                            state <= HDR0;
                        end
                    end else if (timeout_hit) begin
                        // An incomplete header is not a frame, so it is dropped without frame_err.
                        state  <= HDR0;
                        to_cnt <= '0;
                    end else if (to_cnt != TO_MAX) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RECV: begin
                    if (rx_data_vld) begin
                        to_cnt <= '0;
                        if (!byte_phase) begin
                            // The high byte is parked here so bit16_out does not change until the pixel is complete.
                            hi_byte    <= rx_data;
                            byte_phase <= 1'b1;
                        end else begin
                            bit16_out     <= {hi_byte, rx_data};
                            bit16_out_vld <= 1'b1;
                            byte_phase    <= 1'b0;
                            pix_cnt       <= pix_cnt + 20'd1;
                            if (pix_cnt == PIX_LAST) begin
                                frame_done <= 1'b1;
                                frame_busy <= 1'b0;
                                state      <= HDR0;
                            end
                        end
                    end else if (timeout_hit) begin
                        // Discard any half pixel and keep pix_cnt so the partial frame length stays visible.
                        frame_err  <= 1'b1;
                        frame_busy <= 1'b0;
                        byte_phase <= 1'b0;
                        to_cnt     <= '0;
                        state      <= HDR0;
                    end else if (to_cnt != TO_MAX) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    state      <= HDR0;
                    frame_busy <= 1'b0;
                    to_cnt     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_pixel_packer.sv
// Directed bench for uart_pixel_packer with a 4-pixel frame and a 16-cycle timeout.
// Inputs change on the falling edge, and outputs are checked on the following falling edge.

module tb_uart_pixel_packer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_data_vld;
    logic [15:0] bit16_out;
    logic        bit16_out_vld;
    logic        frame_busy;
    logic        frame_done;
    logic        frame_err;
    logic [19:0] pix_cnt;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    uart_pixel_packer #(
        .FRAME_PIXELS  (4),
        .TIMEOUT_CYCLES(16),
        .HEADER0       (8'hA5),
        .HEADER1       (8'h5A)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_data_vld  (rx_data_vld),
        .bit16_out    (bit16_out),
        .bit16_out_vld(bit16_out_vld),
        .frame_busy   (frame_busy),
        .frame_done   (frame_done),
        .frame_err    (frame_err),
        .pix_cnt      (pix_cnt),
        .state_dbg    (state_dbg)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Driver tasks.
    task automatic put(input logic [7:0] b);
        rx_data     = b;
        rx_data_vld = 1'b1;
        @(negedge clk);
        rx_data_vld = 1'b0;
    endtask

    task automatic idle();
        rx_data_vld = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pixel(input string tag, input logic [15:0] px, input logic [19:0] cnt);
        chk({tag, "_vld"}, {31'd0, bit16_out_vld}, 32'd1);
        chk({tag, "_data"}, {16'd0, bit16_out}, {16'd0, px});
        chk({tag, "_cnt"}, {12'd0, pix_cnt}, {12'd0, cnt});
    endtask

    initial begin
        rst_n       = 1'b0;
        rx_data     = 8'h00;
        rx_data_vld = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state.
        chk("rst_data", {16'd0, bit16_out}, 32'h0);
        chk("rst_vld", {31'd0, bit16_out_vld}, 32'd0);
        chk("rst_busy", {31'd0, frame_busy}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk("rst_err", {31'd0, frame_err}, 32'd0);
        chk("rst_cnt", {12'd0, pix_cnt}, 32'd0);
        chk("rst_state", {30'd0, state_dbg}, 32'd0);
        rst_n = 1'b1;
        idle();

        // Full frame with the payload sent back to back.
        put(8'hA5);
        chk("f_hdr0_state", {30'd0, state_dbg}, 32'd1);
        chk("f_hdr0_busy", {31'd0, frame_busy}, 32'd0);
        put(8'h5A);
        chk("f_hdr1_busy", {31'd0, frame_busy}, 32'd1);
        chk("f_hdr1_cnt", {12'd0, pix_cnt}, 32'd0);
        put(8'h12);
        chk("f_p0_half", {31'd0, bit16_out_vld}, 32'd0);
        chk("f_p0_hold", {16'd0, bit16_out}, 32'h0);
        put(8'h34);
        chk_pixel("f_p0", 16'h1234, 20'd1);
        chk("f_p0_done", {31'd0, frame_done}, 32'd0);
        put(8'h56);
        chk("f_p1_half", {31'd0, bit16_out_vld}, 32'd0);
        chk("f_p1_hold", {16'd0, bit16_out}, 32'h1234);
        put(8'h78);
        chk_pixel("f_p1", 16'h5678, 20'd2);
        put(8'h9A);
        chk("f_p2_half", {31'd0, bit16_out_vld}, 32'd0);
        put(8'hBC);
        chk_pixel("f_p2", 16'h9ABC, 20'd3);
        put(8'hDE);
        chk("f_p3_half", {31'd0, bit16_out_vld}, 32'd0);
        put(8'hF0);
        chk_pixel("f_p3", 16'hDEF0, 20'd4);
        chk("f_p3_done", {31'd0, frame_done}, 32'd1);
        chk("f_p3_busy", {31'd0, frame_busy}, 32'd0);
        chk("f_p3_state", {30'd0, state_dbg}, 32'd0);
        idle();
        chk("f_end_done", {31'd0, frame_done}, 32'd0);
        chk("f_end_vld", {31'd0, bit16_out_vld}, 32'd0);
        chk("f_end_hold", {16'd0, bit16_out}, 32'hDEF0);

        // Bytes outside a frame produce nothing, and pix_cnt stays capped.
        put(8'h12);
        put(8'h34);
        chk("f_after_vld", {31'd0, bit16_out_vld}, 32'd0);
        chk("f_after_cnt", {12'd0, pix_cnt}, 32'd4);

        // Header resync with a leading junk byte and a doubled HEADER0.
        put(8'h00);
        chk("rs_junk_state", {30'd0, state_dbg}, 32'd0);
        put(8'hA5);
        chk("rs_a5_state", {30'd0, state_dbg}, 32'd1);
        put(8'hA5);
        chk("rs_a5a5_state", {30'd0, state_dbg}, 32'd1);
        chk("rs_a5a5_vld", {31'd0, bit16_out_vld}, 32'd0);
        put(8'h5A);
        chk("rs_recv_state", {30'd0, state_dbg}, 32'd2);
        chk("rs_recv_cnt", {12'd0, pix_cnt}, 32'd0);
        put(8'h11);
        chk("rs_half", {31'd0, bit16_out_vld}, 32'd0);
        put(8'h22);
        chk_pixel("rs_p0", 16'h1122, 20'd1);

        // Payload timeout with a half pixel (33) pending.
        put(8'h33);
        for (int i = 0; i < 15; i++) idle();
        chk("to_pre_err", {31'd0, frame_err}, 32'd0);
        chk("to_pre_busy", {31'd0, frame_busy}, 32'd1);
        idle();
        chk("to_err", {31'd0, frame_err}, 32'd1);
        chk("to_busy", {31'd0, frame_busy}, 32'd0);
        chk("to_cnt", {12'd0, pix_cnt}, 32'd1);
        chk("to_state", {30'd0, state_dbg}, 32'd0);
        chk("to_vld", {31'd0, bit16_out_vld}, 32'd0);
        idle();
        chk("to_err_pulse", {31'd0, frame_err}, 32'd0);

        // Header timeout returns to HDR0 without frame_err.
        put(8'hA5);
        for (int i = 0; i < 15; i++) idle();
        chk("ht_pre_state", {30'd0, state_dbg}, 32'd1);
        idle();
        chk("ht_state", {30'd0, state_dbg}, 32'd0);
        chk("ht_err", {31'd0, frame_err}, 32'd0);

        // A byte landing on the exact timeout cycle is accepted.
        put(8'hA5);
        put(8'h5A);
        put(8'h11);
        for (int i = 0; i < 15; i++) idle();
        put(8'h22);
        chk_pixel("edge_p0", 16'h1122, 20'd1);
        chk("edge_err", {31'd0, frame_err}, 32'd0);
        chk("edge_busy", {31'd0, frame_busy}, 32'd1);

        // A header pattern inside the payload is pixel data. Then reset mid-frame.
        put(8'hA5);
        put(8'h5A);
        chk_pixel("mid_p1", 16'hA55A, 20'd2);
        put(8'h55);
        put(8'h66);
        chk_pixel("mid_p2", 16'h5566, 20'd3);
        put(8'h77);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_data", {16'd0, bit16_out}, 32'h0);
        chk("mr_busy", {31'd0, frame_busy}, 32'd0);
        chk("mr_cnt", {12'd0, pix_cnt}, 32'd0);
        chk("mr_state", {30'd0, state_dbg}, 32'd0);
        @(negedge clk);
        chk("mr_err", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        put(8'h00);
        put(8'h01);
        chk("mr_nohdr_vld", {31'd0, bit16_out_vld}, 32'd0);
        put(8'hA5);
        put(8'h5A);
        put(8'h00);
        put(8'h01);
        chk_pixel("mr_p0", 16'h0001, 20'd1);
        idle();

        // Final report.
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_pixel_packer.md
UART_PIXEL_PACKER -- requirements
Module: uart_pixel_packer

Interface
REQ-001 SHALL have parameter FRAME_PIXELS, default 921600, meaning pixels per frame (1280*720).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning idle clk cycles between bytes that abort a frame.
REQ-003 SHALL have parameter HEADER0, default 8'hA5, meaning first sync byte.
REQ-004 SHALL have parameter HEADER1, default 8'h5A, meaning second sync byte.
REQ-005 SHALL have port clk  input  1  system clock; all logic is on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port rx_data  input  8  received UART byte.
REQ-008 SHALL have port rx_data_vld  input  1  single-cycle strobe; rx_data is valid this cycle.
REQ-009 SHALL have port bit16_out  output  16  assembled RGB565 pixel.
REQ-010 SHALL have port bit16_out_vld  output  1  single-cycle pixel strobe.
REQ-011 SHALL have port frame_busy  output  1  high while pixel payload is being received.
REQ-012 SHALL have port frame_done  output  1  single-cycle pulse on completion of the last pixel.
REQ-013 SHALL have port frame_err  output  1  single-cycle pulse on payload timeout.
REQ-014 SHALL have port pix_cnt  output  20  pixels completed in the current or last frame.

Function
REQ-015 SHALL implement states HDR0, HDR1 and RECV, with all outputs registered.
REQ-016 HDR0: a byte equal to HEADER0 SHALL move to HDR1; any other byte SHALL be ignored.
REQ-017 HDR1: HEADER1 SHALL move to RECV and clear pix_cnt and the byte phase.
REQ-018 HDR1: HEADER0 SHALL stay in HDR1.
REQ-019 HDR1: any other byte SHALL return to HDR0.
REQ-020 RECV: the first byte of each pair SHALL be latched as bit16_out[15:8], and the second byte as [7:0].
REQ-021 bit16_out_vld SHALL assert one cycle after the clk edge that samples the second byte, and pix_cnt SHALL increment in that same cycle.
REQ-022 bit16_out SHALL hold its last value when bit16_out_vld is low.
REQ-023 When pix_cnt == FRAME_PIXELS-1 and a pixel completes, frame_done SHALL pulse in the same cycle as that bit16_out_vld.
REQ-024 After that final pixel, the state SHALL return to HDR0 and pix_cnt SHALL hold FRAME_PIXELS.
REQ-025 frame_busy SHALL be 1 exactly while the state is RECV.
REQ-026 Bytes arriving in HDR0/HDR1 SHALL never produce bit16_out_vld.
REQ-027 Timeout counter: cleared on every rx_data_vld and on every state change; otherwise it SHALL increment, saturating, in HDR1 and RECV.
REQ-028 Timeout in RECV (counter reaches TIMEOUT_CYCLES-1): frame_err SHALL pulse for 1 cycle, a latched half-byte SHALL be discarded, the state SHALL go to HDR0, and pix_cnt SHALL hold its value.
REQ-029 Timeout in HDR1 SHALL return to HDR0 silently, without frame_err.
REQ-030 rx_data_vld in the same cycle as a timeout SHALL win: the byte is processed and the counter is cleared.
REQ-031 Back-to-back rx_data_vld on consecutive cycles SHALL be accepted with no byte loss.
REQ-032 Throughput SHALL be up to 1 pixel per 2 cycles.
REQ-033 pix_cnt SHALL never exceed FRAME_PIXELS, and the counter width SHALL be 20 bits.
REQ-034 A header sequence seen inside a payload SHALL be treated as pixel data.

Reset
REQ-035 On rst_n low, the state SHALL become HDR0 asynchronously.
REQ-036 On rst_n low, bit16_out SHALL be 16'h0000.
REQ-037 On rst_n low, bit16_out_vld, frame_busy, frame_done and frame_err SHALL be 0.
REQ-038 On rst_n low, pix_cnt, the timeout counter and the byte phase SHALL be 0.
REQ-039 Reset mid-frame SHALL abandon the frame with no frame_err pulse.
REQ-040 After rst_n rises, the block SHALL wait for a new header.

Verification
REQ-041 Frame: with FRAME_PIXELS=4, send A5 5A 12 34 56 78 9A BC DE F0 -> four pixels 1234, 5678, 9ABC, DEF0, each one cycle after its second byte; frame_done coincides with DEF0; pix_cnt=4; state HDR0.
REQ-042 Header resync: send 00 A5 A5 5A 11 22 -> pixel 1122 is output; the leading 00 and the extra A5 produce no pixel.
REQ-043 Timeout: with TIMEOUT_CYCLES=16, send A5 5A 11 22 33, then idle 16 cycles -> one pixel 1122, then a frame_err pulse; byte 33 is dropped; frame_busy=0; pix_cnt=1.
REQ-044 Back-to-back: 8 payload bytes on consecutive cycles -> 4 pixels with bit16_out_vld on alternating cycles and no loss.
REQ-045 Reset mid-frame: assert rst_n after 3 pixels -> all outputs 0 immediately; a following A5 5A 00 01 yields pixel 0001 with pix_cnt=1.
REQ-046 Edge timing: a byte arriving on exactly the timeout cycle -> no frame_err, and the byte is accepted.
